// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU program store and its loader FSM.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        RUN  = 2'd3
    } rom_state_t;

    localparam logic [7:0] NOP_BYTE = 8'h00;

    localparam int ERR_OVF      = 0;
    localparam int ERR_MISALIGN = 1;

endpackage

// File: rtl/rom_mem_256x8.sv
// Program store: one synchronous write port and two asynchronous read ports
// so both instruction bytes are available in the same cycle as the address.
module rom_mem_256x8 #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [7:0]        rdata1,
    output logic [7:0]        rdata2
);

    logic [7:0] mem [0:DEPTH-1];

    // Contents deliberately survive reset: no reset branch on the array.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/program_rom_server.sv
// Instruction-memory responder: byte-serial loader fills the program store,
// then the CPU is released from reset and fetches two bytes per address.
module program_rom_server #(
    parameter int         ADDR_W   = 8,
    parameter int         DEPTH    = 2 ** ADDR_W,
    parameter logic [7:0] NOP_BYTE = cpu_pkg::NOP_BYTE
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              load_start,
    input  logic [7:0]        load_data,
    input  logic              load_valid,
    input  logic              load_last,
    output logic              load_ready,
    output logic [ADDR_W:0]   load_count,
    input  logic [ADDR_W-1:0] rom_address,
    output logic [7:0]        opcode1,
    output logic [7:0]        opcode2,
    output logic              cpu_reset,
    output logic [1:0]        err
);

    import cpu_pkg::*;

    localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W + 1)'(DEPTH);

    rom_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W:0]   load_count_reg;
    logic [1:0]        err_reg;

    logic              accept;
    logic              last_slot;
    logic              start_ok;
    logic              run_active;
    logic [ADDR_W-1:0] raddr2;
    logic [7:0]        rdata1, rdata2;

    assign accept    = (state_reg == LOAD) && load_valid;
    assign last_slot = (wr_ptr_reg == {ADDR_W{1'b1}});
    assign start_ok  = load_start && ((state_reg == IDLE) || (state_reg == RUN));
    assign raddr2    = rom_address + 1'b1;

    // State register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: if (load_start) state_next = LOAD;
            LOAD: if (accept && (load_last || last_slot)) state_next = DONE;
            DONE: state_next = RUN;
            RUN:  if (load_start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cpu_reset  = 1'b1;
        load_ready = 1'b0;
        run_active = 1'b0;
        unique case (state_reg)
            LOAD: load_ready = 1'b1;
            RUN: begin
                cpu_reset  = 1'b0;
                run_active = 1'b1;
            end
            default: ;
        endcase
    end

    // Pointer, count and sticky error flags; a (re)start clears all of them.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_reg     <= '0;
            load_count_reg <= '0;
            err_reg        <= 2'b00;
        end else if (start_ok) begin
            wr_ptr_reg     <= '0;
            load_count_reg <= '0;
            err_reg        <= 2'b00;
        end else begin
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (load_count_reg != COUNT_MAX) begin
                    load_count_reg <= load_count_reg + 1'b1;
                end
                if (last_slot && !load_last) begin
                    err_reg[ERR_OVF] <= 1'b1;
                end
            end
            if (run_active && rom_address[0]) begin
                err_reg[ERR_MISALIGN] <= 1'b1;
            end
        end
    end

    rom_mem_256x8 #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (accept),
        .waddr  (wr_ptr_reg),
        .wdata  (load_data),
        .raddr1 (rom_address),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    assign opcode1    = run_active ? rdata1 : NOP_BYTE;
    assign opcode2    = run_active ? rdata2 : NOP_BYTE;
    assign load_count = load_count_reg;
    assign err        = err_reg;

endmodule
